// File: rtl/seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg_scan_ctrl
//   Multiplexed N-digit 7-segment scan driver. One digit is driven per time
//   slot. Each slot is split into 16 PWM phases of SUB_CYCLES clocks. The digit
//   is lit while phase <= bright_i. Host data is captured into a pending
//   register by load_i. It is committed to the displayed (shadow) register only
//   at a frame boundary, so a frame never mixes old and new data.
//
// Ports
//   clk_i          system clock
//   rst_n_i        asynchronous active-low reset
//   data_i         hex nibbles, data_i[4k+3:4k] = digit k (digit 0 = LSD)
//   dp_in_i        decimal point per digit, 1 = lit
//   load_i         1-cycle strobe, captures data_i/dp_in_i into pending
//   en_i           0 = display dark, counters keep running
//   blank_lz_i     1 = blank leading zero digits (digit 0 never blanked)
//   bright_i       on-time = (bright_i+1)/16 of each slot
//   seg_o          segments {g,f,e,d,c,b,a}
//   dp_o           decimal point
//   dig_sel_o      one-hot digit select
//   frame_done_o   1-cycle pulse on the first cycle of each new frame
//   pending_o      pending data not yet committed
// -----------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int NUM_DIGITS     = 4,
    parameter int SUB_CYCLES     = 8,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [4*NUM_DIGITS-1:0]   data_i,
    input  logic [NUM_DIGITS-1:0]     dp_in_i,
    input  logic                      load_i,
    input  logic                      en_i,
    input  logic                      blank_lz_i,
    input  logic [3:0]                bright_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     dig_sel_o,
    output logic                      frame_done_o,
    output logic                      pending_o
);

    localparam int SUB_W = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);

    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);

    // Inactive output levels; also the reset values.
    localparam logic [6:0]            SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_IDLE  = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] DIG_IDLE = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    // ---------------------------------------------------------------- state
    logic                      run_q, run_d;
    logic [SUB_W-1:0]          sub_q, sub_d;
    logic [3:0]                phase_q, phase_d;
    logic [DIG_W-1:0]          dig_q, dig_d;

    logic [4*NUM_DIGITS-1:0]   pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                      pend_flag_q, pend_flag_d;
    logic [4*NUM_DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]     shadow_dp_q, shadow_dp_d;

    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     dig_sel_q, dig_sel_d;
    logic                      frame_done_q, frame_done_d;

    logic                      frame_end;

    // ------------------------------------------------------------- counters
    // run_q holds the counters at zero for the first edge after reset, so the
    // first edge presents slot 0 / phase 0 and that slot gets its full length.
    always_comb begin
        run_d     = 1'b1;
        sub_d     = sub_q;
        phase_d   = phase_q;
        dig_d     = dig_q;
        frame_end = run_q && (sub_q == SUB_MAX) && (phase_q == 4'hF) && (dig_q == DIG_MAX);
        if (run_q) begin
            if (sub_q == SUB_MAX) begin
                sub_d   = '0;
                phase_d = phase_q + 4'd1;
                if (phase_q == 4'hF) begin
                    dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + DIG_W'(1);
                end
            end else begin
                sub_d = sub_q + SUB_W'(1);
            end
        end
    end

    // ------------------------------------------------------ pending / shadow
    // The commit uses the pending value from before this edge, so a LOAD on the
    // frame-end cycle stays pending until the following frame end.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_flag_d   = pend_flag_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (frame_end) begin
            if (pend_flag_q) begin
                shadow_data_d = pend_data_q;
                shadow_dp_d   = pend_dp_q;
            end
            pend_flag_d = 1'b0;
        end
        if (load_i) begin
            pend_data_d = data_i;
            pend_dp_d   = dp_in_i;
            pend_flag_d = 1'b1;
        end
    end

    // ------------------------------------------------ per-digit decode tables
    logic [3:0]            nib_arr [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blank_vec;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign nib_arr[gi] = shadow_data_d[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blank_vec[gi] = 1'b0;
            end else begin : g_upper
                // Blank when this digit and every more significant digit is zero.
                assign blank_vec[gi] = blank_lz_i &&
                                       (shadow_data_d[4*NUM_DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // --------------------------------------------------------- output decode
    // Outputs are computed from next-state counters/shadow so the registered
    // pins line up exactly with the counter position, with no lag.
    logic                  lit;
    logic [6:0]            seg_raw;
    logic                  dp_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    always_comb begin
        lit     = en_i && (phase_d <= bright_i);
        seg_raw = (lit && !blank_vec[dig_d]) ? glyph(nib_arr[dig_d]) : 7'h00;
        dp_raw  = lit && shadow_dp_d[dig_d];
        dig_raw = lit ? (NUM_DIGITS'(1) << dig_d) : '0;

        seg_d        = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
        dp_d         = (SEG_ACTIVE_LOW != 0) ? ~dp_raw  : dp_raw;
        dig_sel_d    = (DIG_ACTIVE_LOW != 0) ? ~dig_raw : dig_raw;
        frame_done_d = frame_end;
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run_q         <= 1'b0;
            sub_q         <= '0;
            phase_q       <= '0;
            dig_q         <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_flag_q   <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            seg_q         <= SEG_IDLE;
            dp_q          <= DP_IDLE;
            dig_sel_q     <= DIG_IDLE;
            frame_done_q  <= 1'b0;
        end else begin
            run_q         <= run_d;
            sub_q         <= sub_d;
            phase_q       <= phase_d;
            dig_q         <= dig_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_flag_q   <= pend_flag_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            dig_sel_q     <= dig_sel_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_q;
    assign dig_sel_o    = dig_sel_q;
    assign frame_done_o = frame_done_q;
    assign pending_o    = pend_flag_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SUB_CYCLES=2
//   (32-cycle slots, 128-cycle frames). For each frame the expected pin values
//   of all 128 cycles are pushed to a scoreboard queue, then popped and
//   compared cycle by cycle. Host loads are scheduled by frame position.
// -----------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int N     = 4;
    localparam int SUB   = 2;
    localparam int FRAME = 16 * SUB * N;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   data;
    logic [3:0]    dp_in;
    logic          load;
    logic          en;
    logic          blz;
    logic [3:0]    bright;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    dig_sel;
    logic          frame_done;
    logic          pending;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS     (N),
        .SUB_CYCLES     (SUB),
        .SEG_ACTIVE_LOW (0),
        .DIG_ACTIVE_LOW (0)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .data_i       (data),
        .dp_in_i      (dp_in),
        .load_i       (load),
        .en_i         (en),
        .blank_lz_i   (blz),
        .bright_i     (bright),
        .seg_o        (seg),
        .dp_o         (dp),
        .dig_sel_o    (dig_sel),
        .frame_done_o (frame_done),
        .pending_o    (pending)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    typedef struct {
        int          pos;
        logic [15:0] d;
        logic [3:0]  dpv;
    } load_t;

    exp_t  sb_q[$];
    load_t ld_q[$];

    logic [7:0] glyph_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                   8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int total = 0;
    int bad   = 0;

    // Expected display / pending contents
    logic [15:0] cur_data  = '0;
    logic [3:0]  cur_dp    = '0;
    logic [15:0] pend_data = '0;
    logic [3:0]  pend_dp   = '0;
    logic        pend_exp  = 1'b0;

    task automatic chk(input string tag, input int pos, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s pos=%0d observed=%0h expected=%0h", tag, pos, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called while sampling frame position 0; returns while sampling position 127.
    task automatic check_frame(input bit first);
        exp_t  e;
        load_t l;
        int    d, ph;
        logic  lit, blank;
        logic [3:0]  nib;
        logic [15:0] upper;
        int    errs_before;
        errs_before = bad;
        for (int p = 0; p < FRAME; p++) begin
            d     = p / (16 * SUB);
            ph    = (p % (16 * SUB)) / SUB;
            lit   = en && (ph <= int'(bright));
            nib   = cur_data[4*d +: 4];
            upper = cur_data >> (4 * d);
            blank = blz && (d > 0) && (upper == 16'h0);
            e.seg = (lit && !blank) ? glyph_tab[nib][6:0] : 7'h00;
            e.dp  = lit && cur_dp[d];
            e.dig = lit ? (4'b0001 << d) : 4'b0000;
            e.fd  = (p == 0) && !first;
            sb_q.push_back(e);
        end
        for (int p = 0; p < FRAME; p++) begin
            e = sb_q.pop_front();
            chk("seg",        p, 32'(seg),        32'(e.seg));
            chk("dp",         p, 32'(dp),         32'(e.dp));
            chk("dig_sel",    p, 32'(dig_sel),    32'(e.dig));
            chk("frame_done", p, 32'(frame_done), 32'(e.fd));
            chk("pending",    p, 32'(pending),    32'(pend_exp));
            if (p < FRAME - 1) begin
                if (ld_q.size() > 0 && ld_q[0].pos == p) begin
                    l     = ld_q.pop_front();
                    load  = 1'b1;
                    data  = l.d;
                    dp_in = l.dpv;
                    tick();
                    load      = 1'b0;
                    pend_exp  = 1'b1;
                    pend_data = l.d;
                    pend_dp   = l.dpv;
                end else begin
                    tick();
                end
            end
        end
        $display("frame data=%h dp=%b en=%0d bright=%0d blz=%0d errors=%0d",
                 cur_data, cur_dp, en, bright, blz, bad - errs_before);
    endtask

    // Step across the frame-end edge, optionally with a LOAD on that cycle.
    task automatic next_frame(input bit do_load, input logic [15:0] d, input logic [3:0] dpv);
        load  = do_load;
        data  = d;
        dp_in = dpv;
        tick();
        load = 1'b0;
        if (pend_exp) begin
            cur_data = pend_data;
            cur_dp   = pend_dp;
        end
        pend_exp = do_load;
        if (do_load) begin
            pend_data = d;
            pend_dp   = dpv;
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        data   = '0;
        dp_in  = '0;
        load   = 1'b0;
        en     = 1'b1;
        blz    = 1'b0;
        bright = 4'd15;

        // Reset state
        repeat (3) tick();
        chk("rst_seg",     0, 32'(seg),        32'h0);
        chk("rst_dp",      0, 32'(dp),         32'h0);
        chk("rst_dig",     0, 32'(dig_sel),    32'h0);
        chk("rst_fd",      0, 32'(frame_done), 32'h0);
        chk("rst_pending", 0, 32'(pending),    32'h0);

        rst_n = 1'b1;
        tick();
        chk("start_seg", 0, 32'(seg),     32'h3F);
        chk("start_dig", 0, 32'(dig_sel), 32'h1);

        // Load then reset mid-slot: async clear, pending discarded
        load = 1'b1;
        data = 16'h1234;
        tick();
        load = 1'b0;
        chk("load_pending", 1, 32'(pending), 32'h1);
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_seg",     0, 32'(seg),     32'h0);
        chk("async_dig",     0, 32'(dig_sel), 32'h0);
        chk("async_dp",      0, 32'(dp),      32'h0);
        chk("async_pending", 0, 32'(pending), 32'h0);
        #1 rst_n = 1'b1;
        tick();
        $display("reset sequence errors=%0d", bad);

        // First frame after reset shows zeros; LOAD 12AF during it
        ld_q.push_back('{pos: 5, d: 16'h12AF, dpv: 4'b0000});
        check_frame(1'b1);
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        // Brightness
        bright = 4'd3;
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);
        bright = 4'd0;
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        // Leading-zero blanking
        bright = 4'd15;
        blz    = 1'b1;
        next_frame(1'b0, '0, '0);
        ld_q.push_back('{pos: 3, d: 16'h0050, dpv: 4'b1000});
        check_frame(1'b0);
        next_frame(1'b0, '0, '0);
        ld_q.push_back('{pos: 0, d: 16'h0000, dpv: 4'b0000});
        check_frame(1'b0);
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        // Overwrite of pending data mid-frame
        blz = 1'b0;
        next_frame(1'b0, '0, '0);
        ld_q.push_back('{pos: 10, d: 16'h1111, dpv: 4'b0000});
        ld_q.push_back('{pos: 60, d: 16'h2222, dpv: 4'b0000});
        check_frame(1'b0);
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        // LOAD on the frame-end cycle commits one frame later
        next_frame(1'b1, 16'h3333, 4'b0000);
        check_frame(1'b0);
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        // Display disabled: dark, frame_done keeps pulsing
        en = 1'b0;
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);
        next_frame(1'b0, '0, '0);
        check_frame(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
